// File: rtl/pel_pool_rsp.sv
// pel_pool_rsp: ping-pong partial-sum buffer between a PE array (writer)
// and a pooling stage (reader). Two banks alternate: the PE fills one bank
// while the pool drains the other. Writes may overwrite or accumulate
// lane-wise. Any strobe issued against a bank in the wrong state is dropped
// and raises a sticky error flag.
module pel_pool_rsp #(
  parameter  int PSUM_WIDTH  = 16,
  parameter  int BLOCK_DEPTH = 4,
  parameter  int LENPSUM     = 8,
  localparam int AW          = $clog2(LENPSUM * LENPSUM),
  localparam int DW          = PSUM_WIDTH * BLOCK_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          PEPEL_EnWr,
  input  logic [AW-1:0] PEPEL_AddrWr,
  input  logic [DW-1:0] PEPEL_DatWr,
  input  logic          PEPEL_Acc,
  input  logic          PEPEL_Done,
  output logic          PELPE_RdyWr,
  output logic          PELPOOL_ValRow,
  input  logic          POOLPEL_EnRd,
  input  logic [AW-1:0] POOLPEL_AddrRd,
  output logic [DW-1:0] PELPOOL_Dat,
  output logic          PELPOOL_DatVal,
  input  logic          POOLPEL_Release,
  output logic          PELPE_Err
);

  // Both banks share one array; the bank select is the top address bit.
  localparam int MEM_WORDS = 2 ** (AW + 1);

  logic [DW-1:0] mem_q [MEM_WORDS];

  logic [1:0]    full_q, full_d;
  logic          wsel_q, wsel_d;
  logic          rsel_q, rsel_d;
  logic          datval_q, datval_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          err_q, err_d;

  logic          rdy_s;
  logic          val_s;
  logic          wr_ok_s;
  logic          done_ok_s;
  logic          rd_ok_s;
  logic          rel_ok_s;
  logic [DW-1:0] old_s;
  logic [DW-1:0] wr_data_s;

  assign rdy_s          = ~full_q[wsel_q];
  assign val_s          = full_q[rsel_q];
  assign PELPE_RdyWr    = rdy_s;
  assign PELPOOL_ValRow = val_s;
  assign PELPOOL_Dat    = dat_q;
  assign PELPOOL_DatVal = datval_q;
  assign PELPE_Err      = err_q;

  // Qualify strobes and build the write word (overwrite or per-lane wrap add).
  always_comb begin
    wr_ok_s   = PEPEL_EnWr & rdy_s;
    done_ok_s = PEPEL_Done & rdy_s;
    rd_ok_s   = POOLPEL_EnRd & val_s;
    rel_ok_s  = POOLPEL_Release & val_s;
    old_s     = mem_q[{wsel_q, PEPEL_AddrWr}];
    wr_data_s = PEPEL_DatWr;
    if (PEPEL_Acc) begin
      for (int i = 0; i < BLOCK_DEPTH; i++) begin
        wr_data_s[i*PSUM_WIDTH +: PSUM_WIDTH] =
          old_s[i*PSUM_WIDTH +: PSUM_WIDTH] + PEPEL_DatWr[i*PSUM_WIDTH +: PSUM_WIDTH];
      end
    end else begin
      wr_data_s = PEPEL_DatWr;
    end
  end

  // Next-state for bank flags, selects, read port and sticky error.
  always_comb begin
    full_d   = full_q;
    wsel_d   = wsel_q;
    rsel_d   = rsel_q;
    datval_d = rd_ok_s;
    dat_d    = dat_q;
    err_d    = err_q;
    // Done and Release can only both succeed on different banks, so the
    // two flag updates never collide.
    if (done_ok_s) begin
      full_d[wsel_q] = 1'b1;
      wsel_d         = ~wsel_q;
    end else begin
      wsel_d = wsel_q;
    end
    if (rel_ok_s) begin
      full_d[rsel_q] = 1'b0;
      rsel_d         = ~rsel_q;
    end else begin
      rsel_d = rsel_q;
    end
    // A read in the releasing cycle is still served from the old bank.
    if (rd_ok_s) begin
      dat_d = mem_q[{rsel_q, POOLPEL_AddrRd}];
    end else begin
      dat_d = dat_q;
    end
    if ((PEPEL_EnWr & ~rdy_s) | (PEPEL_Done & ~rdy_s) |
        (POOLPEL_EnRd & ~val_s) | (POOLPEL_Release & ~val_s)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= 2'b00;
      wsel_q   <= 1'b0;
      rsel_q   <= 1'b0;
      datval_q <= 1'b0;
      dat_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      full_q   <= full_d;
      wsel_q   <= wsel_d;
      rsel_q   <= rsel_d;
      datval_q <= datval_d;
      dat_q    <= dat_d;
      err_q    <= err_d;
    end
  end

  // Buffer storage; contents survive reset, only the bank flags are cleared.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[{wsel_q, PEPEL_AddrWr}] <= wr_data_s;
    end
  end

endmodule

// File: tb/tb_pel_pool_rsp.sv
// Directed bench for pel_pool_rsp: inputs change 1 time unit after a rising
// edge, outputs are checked at that same point after the following edge.
module tb_pel_pool_rsp;

  localparam int AW = 6;
  localparam int DW = 64;

  logic          clk;
  logic          rst_n;
  logic          en_wr;
  logic [AW-1:0] addr_wr;
  logic [DW-1:0] dat_wr;
  logic          acc;
  logic          done;
  logic          rdy_wr;
  logic          val_row;
  logic          en_rd;
  logic [AW-1:0] addr_rd;
  logic [DW-1:0] dat;
  logic          dat_val;
  logic          release_s;
  logic          err;

  int total  = 0;
  int passed = 0;

  pel_pool_rsp dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .PEPEL_EnWr      (en_wr),
    .PEPEL_AddrWr    (addr_wr),
    .PEPEL_DatWr     (dat_wr),
    .PEPEL_Acc       (acc),
    .PEPEL_Done      (done),
    .PELPE_RdyWr     (rdy_wr),
    .PELPOOL_ValRow  (val_row),
    .POOLPEL_EnRd    (en_rd),
    .POOLPEL_AddrRd  (addr_rd),
    .PELPOOL_Dat     (dat),
    .PELPOOL_DatVal  (dat_val),
    .POOLPEL_Release (release_s),
    .PELPE_Err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_wr     = 1'b0;
    addr_wr   = '0;
    dat_wr    = '0;
    acc       = 1'b0;
    done      = 1'b0;
    en_rd     = 1'b0;
    addr_rd   = '0;
    release_s = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_rdy",    64'(rdy_wr),  64'd1);
    chk("rst_val",    64'(val_row), 64'd0);
    chk("rst_datval", 64'(dat_val), 64'd0);
    chk("rst_dat",    dat,          64'd0);
    chk("rst_err",    64'(err),     64'd0);
    rst_n = 1'b1;
    tick();

    // Basic overwrite, close bank 0, read back.
    en_wr = 1'b1; addr_wr = 6'd5; dat_wr = 64'h0004_0003_0002_0001; acc = 1'b0;
    tick();
    idle(); done = 1'b1;
    tick();
    idle();
    chk("t1_val", 64'(val_row), 64'd1);
    chk("t1_rdy", 64'(rdy_wr),  64'd1);
    en_rd = 1'b1; addr_rd = 6'd5;
    tick();
    idle();
    chk("t1_datval", 64'(dat_val), 64'd1);
    chk("t1_dat",    dat,          64'h0004_0003_0002_0001);
    tick();
    chk("t1_datval_off", 64'(dat_val), 64'd0);
    chk("t1_dat_hold",   dat,          64'h0004_0003_0002_0001);

    // Lane-wise wrap accumulate into bank 1, then both banks full.
    en_wr = 1'b1; addr_wr = 6'd0; dat_wr = 64'hFFFF_FFFF_FFFF_FFFF; acc = 1'b0;
    tick();
    dat_wr = 64'h0002_0002_0002_0002; acc = 1'b1;
    tick();
    idle(); done = 1'b1;
    tick();
    idle();
    chk("full_rdy", 64'(rdy_wr),  64'd0);
    chk("full_val", 64'(val_row), 64'd1);
    chk("full_err", 64'(err),     64'd0);
    // Dropped write aimed at bank 0 address 5.
    en_wr = 1'b1; addr_wr = 6'd5; dat_wr = 64'h1234_5678_9ABC_DEF0; acc = 1'b0;
    tick();
    idle();
    chk("drop_err", 64'(err), 64'd1);
    release_s = 1'b1;
    tick();
    idle();
    chk("rel_rdy", 64'(rdy_wr),  64'd1);
    chk("rel_val", 64'(val_row), 64'd1);
    en_rd = 1'b1; addr_rd = 6'd0;
    tick();
    idle();
    chk("acc_datval", 64'(dat_val), 64'd1);
    chk("acc_dat",    dat,          64'h0001_0001_0001_0001);

    // Refill bank 0; accumulating on addr 5 exposes whether the drop corrupted it.
    en_wr = 1'b1; addr_wr = 6'd5; dat_wr = 64'h0001_0001_0001_0001; acc = 1'b1;
    tick();
    addr_wr = 6'd7; dat_wr = 64'hAAAA_5555_0F0F_F0F0; acc = 1'b0;
    tick();
    idle();
    // Read + Release + Done together.
    en_rd = 1'b1; addr_rd = 6'd0; release_s = 1'b1; done = 1'b1;
    tick();
    idle();
    chk("combo_datval", 64'(dat_val), 64'd1);
    chk("combo_dat",    dat,          64'h0001_0001_0001_0001);
    chk("combo_val",    64'(val_row), 64'd1);
    chk("combo_rdy",    64'(rdy_wr),  64'd1);
    // Back-to-back reads from bank 0.
    en_rd = 1'b1; addr_rd = 6'd5;
    tick();
    addr_rd = 6'd7;
    chk("b2b0_datval", 64'(dat_val), 64'd1);
    chk("b2b0_dat",    dat,          64'h0005_0004_0003_0002);
    tick();
    idle();
    chk("b2b1_datval", 64'(dat_val), 64'd1);
    chk("b2b1_dat",    dat,          64'hAAAA_5555_0F0F_F0F0);

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_datval", 64'(dat_val), 64'd0);
    chk("arst_dat",    dat,          64'd0);
    chk("arst_err",    64'(err),     64'd0);
    chk("arst_rdy",    64'(rdy_wr),  64'd1);
    chk("arst_val",    64'(val_row), 64'd0);
    rst_n = 1'b1;
    tick();

    // Read with no valid bank.
    en_rd = 1'b1; addr_rd = 6'd5;
    tick();
    idle();
    chk("badrd_datval", 64'(dat_val), 64'd0);
    chk("badrd_err",    64'(err),     64'd1);
    chk("badrd_dat",    dat,          64'd0);
    tick();
    chk("err_sticky",   64'(err),     64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pel_pool_rsp.md
PEL_POOL_RSP -- requirements
Module: pel_pool_rsp

Interface
REQ-001 Parameter PSUM_WIDTH, default 16, width of one partial-sum lane.
REQ-002 Parameter BLOCK_DEPTH, default 4, number of lanes per buffer word.
REQ-003 Parameter LENPSUM, default 8; entries per bank = LENPSUM*LENPSUM = 64; AW = ceil(log2(LENPSUM*LENPSUM)) = 6.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 PEPEL_EnWr  in  1  PE write strobe.
REQ-007 PEPEL_AddrWr  in  AW  PE write address.
REQ-008 PEPEL_DatWr  in  PSUM_WIDTH*BLOCK_DEPTH  PE write data; lane i = bits [i*PSUM_WIDTH +: PSUM_WIDTH].
REQ-009 PEPEL_Acc  in  1  1 = accumulate into entry, 0 = overwrite.
REQ-010 PEPEL_Done  in  1  tile complete; closes the current write bank.
REQ-011 PELPE_RdyWr  out  1  write bank is free.
REQ-012 PELPOOL_ValRow  out  1  read bank holds a complete tile.
REQ-013 POOLPEL_EnRd  in  1  pool read strobe.
REQ-014 POOLPEL_AddrRd  in  AW  pool read address.
REQ-015 PELPOOL_Dat  out  PSUM_WIDTH*BLOCK_DEPTH  read data.
REQ-016 PELPOOL_DatVal  out  1  PELPOOL_Dat valid this cycle.
REQ-017 POOLPEL_Release  in  1  pool finished with read bank.
REQ-018 PELPE_Err  out  1  sticky protocol-error flag.

Function
REQ-019 Two banks (0,1) of 64 words; per-bank full flag; write select wsel; read select rsel.
REQ-020 PELPE_RdyWr = ~full[wsel]; PELPOOL_ValRow = full[rsel]; both combinational from registers.
REQ-021 Write with EnWr=1 and RdyWr=1: Acc=0 stores DatWr at bank[wsel][AddrWr]; Acc=1 stores per-lane (old + DatWr) mod 2^PSUM_WIDTH, no carry between lanes; result visible from next cycle.
REQ-022 Write with EnWr=1 and RdyWr=0: dropped, memory unchanged, PELPE_Err set.
REQ-023 Done=1 with RdyWr=1: full[wsel] set, wsel toggles; a write in the same cycle lands in the closing bank first.
REQ-024 Done=1 with RdyWr=0: ignored, PELPE_Err set.
REQ-025 Read with EnRd=1 and ValRow=1: PELPOOL_Dat = bank[rsel][AddrRd] and DatVal=1 exactly one cycle later; back-to-back reads give one word per cycle.
REQ-026 Read with EnRd=1 and ValRow=0: no data, DatVal=0 next cycle, PELPE_Err set.
REQ-027 PELPOOL_Dat holds its last value when DatVal=0.
REQ-028 Release=1 with ValRow=1: full[rsel] cleared, rsel toggles; a read in the same cycle is served from the releasing bank.
REQ-029 Release=1 with ValRow=0: ignored, PELPE_Err set.
REQ-030 Done and Release in the same cycle on different banks: both take effect.
REQ-031 With both banks full, RdyWr=0 until a Release; wsel and rsel then point to the same bank, which is empty.

Reset
REQ-032 rst_n=0 forces full[1:0]=0, wsel=0, rsel=0, PELPOOL_DatVal=0, PELPOOL_Dat=0, PELPE_Err=0 immediately, regardless of clk.
REQ-033 Memory contents are not reset; a reset mid-tile discards that tile logically because both banks return to empty.
REQ-034 PELPE_Err clears only on reset.

Verification
REQ-035 Reset, then write addr 5 = 0x0004_0003_0002_0001 with Acc=0, then Done -> ValRow=1, RdyWr=1 (bank 1 free); EnRd addr 5 -> next cycle DatVal=1, Dat=0x0004_0003_0002_0001.
REQ-036 Write addr 0 = lanes 0xFFFF with Acc=0, then lanes 0x0002 with Acc=1, then Done; read addr 0 -> every lane 0x0001 (wrap, no cross-lane carry).
REQ-037 Fill and close both banks -> RdyWr=0; one more write -> dropped, Err=1; Release -> RdyWr=1, ValRow=1 (bank 1), data from bank 1 returned.
REQ-038 EnRd, Release and Done all in the same cycle with bank 0 full and bank 1 filling -> read returns bank 0 data, then ValRow stays 1 with rsel=1 and wsel=0.
REQ-039 EnRd with ValRow=0 -> DatVal stays 0, Err=1; assert rst_n=0 mid-stream -> all outputs return to reset values within the same cycle.
